// File: rtl/muldiv_pkg.sv
// Shared EXE muldiv definitions: RV32M op encodings, FSM state encodings common
// with the divider, and the iteration-counter width.
package muldiv_pkg;

  localparam int MD_XLEN = 32;
  localparam int CNT_W   = $clog2(MD_XLEN + 1);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the product register. MUL_RADIX4_EN selects two
// multiplier bits per step (0/1/2/3 x mcand) instead of one.
module mul_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   mcand_i,
  output logic [2*XLEN-1:0] prod_o
);

`ifdef MUL_RADIX4_EN
  logic [XLEN+1:0] m1, m2, m3, addend, sum;

  always_comb begin
    m1 = {2'b00, mcand_i};
    m2 = {1'b0, mcand_i, 1'b0};
    m3 = m1 + m2;
    case (prod_i[1:0])
      2'b00:   addend = '0;
      2'b01:   addend = m1;
      2'b10:   addend = m2;
      default: addend = m3;
    endcase
    // hi half plus up to 3*mcand never exceeds XLEN+2 bits
    sum    = {2'b00, prod_i[2*XLEN-1:XLEN]} + addend;
    prod_o = {sum, prod_i[XLEN-1:2]};
  end
`else
  logic [XLEN:0] sum;

  always_comb begin
    sum    = {1'b0, prod_i[2*XLEN-1:XLEN]} + (prod_i[0] ? {1'b0, mcand_i} : '0);
    prod_o = {sum, prod_i[XLEN-1:1]};
  end
`endif

endmodule

// File: rtl/mul.sv
// Sequential shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) with the
// divider's req/ready/flush handshake. Define MUL_RADIX4_EN for radix-4 steps.
module mul
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      op_i,
  input  logic            flush_i,
  input  logic            req_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(XLEN + 1);
`ifdef MUL_RADIX4_EN
  localparam int STEPS = XLEN / 2;
`else
  localparam int STEPS = XLEN;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_step, p;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  op_e               op_q, op_d;
  logic              neg_q, neg_d, ready_q, ready_d;
  logic              a_neg, b_neg;

  mul_step #(.XLEN(XLEN)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (prod_step)
  );

  always_comb begin
    // a is signed for MULH/MULHSU, b only for MULH
    a_neg = a_i[XLEN-1] & (op_i == OP_MULH || op_i == OP_MULHSU);
    b_neg = b_i[XLEN-1] & (op_i == OP_MULH);
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    p     = neg_q ? -prod_q : prod_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      S_IDLE: if (req_i) begin
        op_d    = op_e'(op_i);
        mcand_d = a_mag;
        cnt_d   = CW'(STEPS);
        if (a_i == '0 || b_i == '0) begin
          prod_d  = '0;
          neg_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          prod_d  = {{XLEN{1'b0}}, b_mag};
          neg_d   = a_neg ^ b_neg;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = (op_q == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        ready_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = '0;
      ready_d  = 1'b0;
    end else if (!req_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corner cases, flush/abort/reset, and
// randomized operands against a 64-bit arithmetic reference.
module tb_mul;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 32 / 2 + 2;
`else
  localparam int LAT = 32 + 2;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [1:0]  op_i = '0;
  logic        flush_i = 1'b0, req_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  mul dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .op_i     (op_i),
    .flush_i  (flush_i),
    .req_i    (req_i),
    .result_o (result_o),
    .ready_o  (ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] sa, sb, pr;
    sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    pr = sa * sb;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input string tag);
    int n;
    bit seen;
    logic [31:0] exp;
    int exp_lat;
    exp     = ref_mul(a, b, op);
    exp_lat = (a == 0 || b == 0) ? 2 : LAT;
    @(negedge clk_i);
    a_i = a; b_i = b; op_i = op; req_i = 1'b1;
    n = 0; seen = 0;
    while (n < 200 && !seen) begin
      @(posedge clk_i); #1;
      n++;
      if (ready_o) seen = 1;
      else if (n == 1) begin
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
      end
    end
    req_i = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, {32'b0, result_o}, {32'b0, exp});
    @(posedge clk_i); #1;
    chk({tag, "_pulse"}, {63'b0, ready_o}, 64'd0);
  endtask

  initial begin
    bit any_rdy;
    logic [31:0] ra, rb;
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    #12;
    chk("rst_result", {32'b0, result_o}, 64'd0);
    chk("rst_ready", {63'b0, ready_o}, 64'd0);
    @(negedge clk_i); rst_i = 1'b1;

    do_op(32'd7, 32'd6, 2'b00, "mul_7x6");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, "mulhu_ff");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "mul_ff");
    do_op(32'h8000_0000, 32'h8000_0000, 2'b01, "mulh_min");
    do_op(32'hFFFF_FFFF, 32'd2, 2'b10, "mulhsu_m1x2");
    do_op(32'h0, 32'h1234_5678, 2'b00, "mul_zero");
    do_op(32'hFFFF_FFF9, 32'd6, 2'b01, "mulh_neg");
    chk("spec_mulh_min", {32'b0, ref_mul(32'h8000_0000, 32'h8000_0000, 2'b01)}, 64'h4000_0000);

    // flush at CALC cycle 10, request still asserted
    @(negedge clk_i);
    a_i = 32'h1234; b_i = 32'h5678; op_i = 2'b00; req_i = 1'b1;
    any_rdy = 0;
    repeat (11) begin @(posedge clk_i); #1; if (ready_o) any_rdy = 1; end
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1;
    if (ready_o) any_rdy = 1;
    chk("flush_result", {32'b0, result_o}, 64'd0);
    @(negedge clk_i); flush_i = 1'b0; req_i = 1'b0;
    repeat (LAT) begin @(posedge clk_i); #1; if (ready_o) any_rdy = 1; end
    chk("flush_no_ready", {63'b0, any_rdy}, 64'd0);
    do_op(32'd3, 32'd5, 2'b00, "mul_3x5");

    // req dropped mid-CALC
    @(negedge clk_i);
    a_i = 32'd100; b_i = 32'd200; op_i = 2'b00; req_i = 1'b1;
    any_rdy = 0;
    repeat (5) begin @(posedge clk_i); #1; if (ready_o) any_rdy = 1; end
    @(negedge clk_i); req_i = 1'b0;
    repeat (LAT + 4) begin @(posedge clk_i); #1; if (ready_o) any_rdy = 1; end
    chk("drop_no_ready", {63'b0, any_rdy}, 64'd0);
    chk("drop_result_kept", {32'b0, result_o}, 64'd15);

    // async reset mid-CALC
    @(negedge clk_i);
    a_i = 32'd9; b_i = 32'd9; op_i = 2'b00; req_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_result", {32'b0, result_o}, 64'd0);
    chk("arst_ready", {63'b0, ready_o}, 64'd0);
    @(negedge clk_i); req_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    do_op(32'd9, 32'd9, 2'b00, "post_rst");

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      do_op(ra, rb, 2'($urandom), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
